axi4lite_cmd_sequencer: RTL

- Sits directly upstream of axi4lite_master and converts a queue of host commands into master start_write/start_read transactions.
- Buffers commands in a small FIFO, issues them one at a time, waits for master done (with timeout), and returns one response per command through a valid/ready port.
- Lets the host stream writes and reads back-to-back without polling done.

---
 rtl/axi4lite_pkg.sv | 24 ++
 rtl/axi4lite_cmd_sequencer_if.sv | 27 ++
 rtl/axi4lite_cmd_fifo.sv | 50 +++++
 rtl/axi4lite_cmd_sequencer.sv | 120 ++++++++++++
 4 files changed

// File: rtl/axi4lite_pkg.sv
// Shared types for the AXI4-Lite command sequencer: op encodings, FSM states
// and the default-width command record.
package axi4lite_pkg;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int CMD_ADDR_W = 2;
    localparam int CMD_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic                  op;
        logic [CMD_ADDR_W-1:0] addr;
        logic [CMD_DATA_W-1:0] wdata;
    } cmd_t;

endpackage

// File: rtl/axi4lite_cmd_sequencer_if.sv
// Host-side command/response channel of the sequencer; master = host,
// slave = sequencer.
interface axi4lite_cmd_sequencer_if #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_op;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_op;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_timeout;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_op, rsp_rdata, rsp_timeout
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_op, rsp_rdata, rsp_timeout
    );
endinterface

// File: rtl/axi4lite_cmd_fifo.sv
// Generic synchronous first-word-fall-through FIFO; the head entry is always
// visible on rdata while not empty.
module axi4lite_cmd_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/axi4lite_cmd_sequencer.sv
// Queues host commands and issues them one at a time to axi4lite_master,
// returning one response (data or timeout) per command.
//   state | meaning
//   IDLE  | wait for a queued command, pop it into cur_*
//   ISSUE | one-cycle start_write/start_read pulse, clear timeout counter
//   WAIT  | wait for done or timeout, capture response
//   RESP  | present response until rsp_ready
module axi4lite_cmd_sequencer
    import axi4lite_pkg::*;
#(
    parameter int ADDR_WIDTH     = 2,
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst_n,
    axi4lite_cmd_sequencer_if.slave       host,
    output logic                          start_write,
    output logic                          start_read,
    output logic [ADDR_WIDTH-1:0]         write_addr,
    output logic [DATA_WIDTH-1:0]         write_data,
    output logic [ADDR_WIDTH-1:0]         read_addr,
    input  logic                          done,
    input  logic [DATA_WIDTH-1:0]         read_data,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int ENTRY_W = 1 + ADDR_WIDTH + DATA_WIDTH;
    localparam int TMO_W   = $clog2(TIMEOUT_CYCLES);

    seq_state_e             state;
    seq_state_e             state_nxt;
    logic [ENTRY_W-1:0]     head;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   fifo_pop;
    logic                   cur_op;
    logic [ADDR_WIDTH-1:0]  cur_addr;
    logic [DATA_WIDTH-1:0]  cur_wdata;
    logic [TMO_W-1:0]       tmo_cnt;
    logic                   tmo_last;
    logic                   rsp_op_q;
    logic [DATA_WIDTH-1:0]  rsp_rdata_q;
    logic                   rsp_timeout_q;

    axi4lite_cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (host.cmd_valid & host.cmd_ready),
        .pop   (fifo_pop),
        .wdata ({host.cmd_op, host.cmd_addr, host.cmd_wdata}),
        .rdata (head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign tmo_last = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        fifo_pop  = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_nxt = ISSUE;
                    fifo_pop  = 1'b1;
                end
            end
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done || tmo_last) state_nxt = RESP;
            RESP:    if (host.rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // done has priority over the final timeout count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_op        <= OP_READ;
            cur_addr      <= '0;
            cur_wdata     <= '0;
            tmo_cnt       <= '0;
            rsp_op_q      <= OP_READ;
            rsp_rdata_q   <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            if (fifo_pop) {cur_op, cur_addr, cur_wdata} <= head;
            if (state == ISSUE)     tmo_cnt <= '0;
            else if (state == WAIT) tmo_cnt <= tmo_cnt + 1'b1;
            if (state == WAIT && (done || tmo_last)) begin
                rsp_op_q      <= cur_op;
                rsp_timeout_q <= ~done;
                rsp_rdata_q   <= (done && cur_op == OP_READ) ? read_data : '0;
            end
        end
    end

    assign host.cmd_ready   = ~fifo_full;
    assign host.rsp_valid   = (state == RESP);
    assign host.rsp_op      = rsp_op_q;
    assign host.rsp_rdata   = rsp_rdata_q;
    assign host.rsp_timeout = rsp_timeout_q;

    assign start_write = (state == ISSUE) && (cur_op == OP_WRITE);
    assign start_read  = (state == ISSUE) && (cur_op == OP_READ);
    assign write_addr  = cur_addr;
    assign write_data  = cur_wdata;
    assign read_addr   = cur_addr;
    assign busy        = (state != IDLE) || !fifo_empty;
endmodule
